ram2gyro_cmd: RTL and testbench

Mailbox reader that polls a 16-byte command region of the shared PS/PL byte RAM and replays the register writes it finds to the gyro/magnetometer bus controller. It pairs with the sensor-to-RAM writer, which fills bytes 0x00–0x0F. This block owns a separate window at BASE_ADDR. When the PS posts a command block, the block reads it, issues each (register, value) pair over a valid/ready interface, then writes an acknowledge byte back to the mailbox.

---
 rtl/ram2gyro_cmd_if.sv | 22 ++
 rtl/ram2gyro_cmd.sv | 175 +++++++++++++++++
 tb/tb_ram2gyro_cmd.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram2gyro_cmd_if.sv
// RAM byte port plus register-write request channel used by ram2gyro_cmd.
// The master side is the mailbox reader; the slave side is RAM + bus controller.
interface ram2gyro_cmd_if;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wen;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_val;

  modport master (
    output addr, data_out, wen, cmd_valid, cmd_reg, cmd_val,
    input  data_in, cmd_ready
  );

  modport slave (
    input  addr, data_out, wen, cmd_valid, cmd_reg, cmd_val,
    output data_in, cmd_ready
  );
endinterface

// File: rtl/ram2gyro_cmd.sv
// Polls a 16-byte mailbox in shared RAM, replays its (register, value) pairs
// as valid/ready write requests, then writes an acknowledge byte to the flag.
module ram2gyro_cmd #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter int         POLL_DIV  = 1000,
  parameter int         READ_LAT  = 2
) (
  input  logic clk,
  input  logic rst_n,
  ram2gyro_cmd_if.master bus,
  output logic busy,
  output logic done
);

  localparam int PW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam int LW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_DIV - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(READ_LAT - 1);

  localparam logic [7:0] FLAG_PENDING = 8'hA5;
  localparam logic [7:0] ACK_OK       = 8'h00;
  localparam logic [7:0] ACK_ERR      = 8'hEE;
  localparam logic [2:0] MAX_PAIRS    = 3'd7;

  typedef enum logic [2:0] {
    IDLE, RD_FLAG, RD_CNT, RD_REG, RD_VAL, SEND, ACK
  } state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [LW-1:0] lat_cnt;
  logic [2:0]    k;
  logic [2:0]    count;
  logic          err;

  logic [2:0] k_next;
  logic [7:0] next_reg_addr;
  logic [7:0] val_addr;

  // Pair k lives at +2+2k (register) and +3+2k (value); 8-bit adds wrap mod 256.
  assign k_next        = k + 3'd1;
  assign next_reg_addr = BASE_ADDR + 8'd2 + {4'b0000, k_next, 1'b0};
  assign val_addr      = BASE_ADDR + 8'd3 + {4'b0000, k, 1'b0};

  // NOTE: every register in this block, including the bus outputs, updates
  // with non-blocking assignments so all state moves together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the async reset restores every output register; there is no
      // memory here, so nothing is left holding stale mailbox content.
      state         <= IDLE;
      poll_cnt      <= POLL_LOAD;
      lat_cnt       <= '0;
      k             <= '0;
      count         <= '0;
      err           <= 1'b0;
      bus.addr      <= BASE_ADDR;
      bus.data_out  <= 8'h00;
      bus.wen       <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_reg   <= 8'h00;
      bus.cmd_val   <= 8'h00;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      bus.wen <= 1'b0;
      done    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (poll_cnt == '0) begin
            bus.addr <= BASE_ADDR;
            lat_cnt  <= LAT_LOAD;
            busy     <= 1'b1;
            state    <= RD_FLAG;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
        end

        RD_FLAG: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else if (bus.data_in == FLAG_PENDING) begin
            bus.addr <= BASE_ADDR + 8'd1;
            lat_cnt  <= LAT_LOAD;
            state    <= RD_CNT;
          end else begin
            poll_cnt <= POLL_LOAD;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        RD_CNT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            k <= '0;
            if (bus.data_in > 8'd7) begin
              count <= MAX_PAIRS;
              err   <= 1'b1;
            end else begin
              count <= bus.data_in[2:0];
              err   <= 1'b0;
            end
            if (bus.data_in == 8'h00) begin
              // Empty block: acknowledge straight away, never an error.
              bus.addr     <= BASE_ADDR;
              bus.data_out <= ACK_OK;
              bus.wen      <= 1'b1;
              state        <= ACK;
            end else begin
              bus.addr <= BASE_ADDR + 8'd2;
              lat_cnt  <= LAT_LOAD;
              state    <= RD_REG;
            end
          end
        end

        RD_REG: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            bus.cmd_reg <= bus.data_in;
            bus.addr    <= val_addr;
            lat_cnt     <= LAT_LOAD;
            state       <= RD_VAL;
          end
        end

        RD_VAL: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            bus.cmd_val   <= bus.data_in;
            bus.cmd_valid <= 1'b1;
            state         <= SEND;
          end
        end

        SEND: begin
          if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            k             <= k_next;
            if (k_next < count) begin
              bus.addr <= next_reg_addr;
              lat_cnt  <= LAT_LOAD;
              state    <= RD_REG;
            end else begin
              bus.addr     <= BASE_ADDR;
              bus.data_out <= err ? ACK_ERR : ACK_OK;
              bus.wen      <= 1'b1;
              state        <= ACK;
            end
          end
        end

        ACK: begin
          poll_cnt <= POLL_LOAD;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          poll_cnt <= POLL_LOAD;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram2gyro_cmd.sv
// Bench for ram2gyro_cmd: a latency-modelled RAM, a PS that posts mailbox
// blocks, and a bus controller whose ready behaviour is selectable.
module tb_ram2gyro_cmd;

  localparam logic [7:0] BASE = 8'hF8;  // region wraps past 8'hFF
  localparam int P = 16;
  localparam int R = 3;

  logic clk;
  logic rst_n;
  logic busy;
  logic done;

  ram2gyro_cmd_if bus ();

  ram2gyro_cmd #(.BASE_ADDR(BASE), .POLL_DIV(P), .READ_LAT(R)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: data for an address becomes visible R-1 edges after the address.
  logic [7:0] mem [256];
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= mem[bus.addr];
    rd2 <= rd1;
  end
  assign bus.data_in = rd2;

  // Bus controller: 0 never ready, 1 always ready, 2 stall 5 cycles, 3 random.
  int ready_mode;
  int stall_n;
  always @(negedge clk) begin
    case (ready_mode)
      0: bus.cmd_ready = 1'b0;
      1: bus.cmd_ready = 1'b1;
      2: begin
        if (bus.cmd_valid && !bus.cmd_ready) begin
          stall_n++;
          if (stall_n >= 5) bus.cmd_ready = 1'b1;
        end else begin
          bus.cmd_ready = 1'b0;
          stall_n = 0;
        end
      end
      default: bus.cmd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Observation of everything the DUT does, one record per cycle.
  int cyc, rise_cyc, wen_cyc, done_cyc, n_done, valid_cnt, stall_err, dbl_err;
  logic busy_q, stall_q, xfer_prev;
  logic [15:0] stall_pay;
  logic [15:0] xfer_q [$];
  logic [15:0] wen_q [$];
  int rise_q [$];
  int len_q [$];

  initial begin
    cyc = 0; n_done = 0; valid_cnt = 0; stall_err = 0; dbl_err = 0;
    busy_q = 1'b0; stall_q = 1'b0; xfer_prev = 1'b0; stall_pay = '0;
    rise_cyc = 0; wen_cyc = 0; done_cyc = 0;
  end

  always @(posedge clk) begin
    if (busy && !busy_q) begin
      rise_cyc = cyc;
      rise_q.push_back(cyc);
    end
    if (!busy && busy_q) len_q.push_back(cyc - rise_cyc);
    busy_q = busy;
    if (bus.wen) begin
      wen_q.push_back({bus.addr, bus.data_out});
      wen_cyc = cyc;
    end
    if (done) begin
      done_cyc = cyc;
      n_done++;
    end
    if (bus.cmd_valid) valid_cnt++;
    if (xfer_prev && bus.cmd_valid) dbl_err++;
    if (stall_q && bus.cmd_valid && ({bus.cmd_reg, bus.cmd_val} !== stall_pay)) stall_err++;
    xfer_prev = bus.cmd_valid && bus.cmd_ready;
    if (xfer_prev) xfer_q.push_back({bus.cmd_reg, bus.cmd_val});
    stall_q   = bus.cmd_valid && !bus.cmd_ready;
    stall_pay = {bus.cmd_reg, bus.cmd_val};
    cyc++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] at(input int off);
    return 8'(int'(BASE) + off);
  endfunction

  logic [7:0] pay [14];

  task automatic randomize_pay();
    for (int i = 0; i < 14; i++) pay[i] = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},      32'(bus.addr),      32'(BASE));
    check({tag, "_data_out"},  32'(bus.data_out),  32'h0);
    check({tag, "_wen"},       32'(bus.wen),       32'h0);
    check({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'h0);
    check({tag, "_cmd_reg"},   32'(bus.cmd_reg),   32'h0);
    check({tag, "_cmd_val"},   32'(bus.cmd_val),   32'h0);
    check({tag, "_busy"},      32'(busy),          32'h0);
    check({tag, "_done"},      32'(done),          32'h0);
  endtask

  // Post a block (unless already in RAM), wait for its done pulse, and
  // compare against the mailbox rules: min(N,7) pairs in order, one ack.
  task automatic run_block(input int n, input string tag, input bit timed, input bit post);
    int m, x0, w0, v0, d0, t;
    logic [7:0] ack;
    m   = (n > 7) ? 7 : n;
    ack = (n > 7) ? 8'hEE : 8'h00;
    x0 = xfer_q.size(); w0 = wen_q.size(); v0 = valid_cnt; d0 = n_done;
    if (post) begin
      mem[at(1)] = 8'(n);
      for (int i = 0; i < 14; i++) mem[at(2 + i)] = pay[i];
      mem[at(0)] = 8'hA5;
    end
    t = 0;
    while (n_done == d0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    check({tag, "_done_seen"}, 32'(n_done != d0), 32'h1);
    check({tag, "_xfer_count"}, 32'(xfer_q.size() - x0), 32'(m));
    for (int i = 0; i < m && (x0 + i) < xfer_q.size(); i++)
      check($sformatf("%s_pair%0d", tag, i), 32'(xfer_q[x0 + i]), 32'({pay[2*i], pay[2*i+1]}));
    check({tag, "_wen_count"}, 32'(wen_q.size() - w0), 32'h1);
    if (wen_q.size() > w0)
      check({tag, "_ack"}, 32'(wen_q[w0]), 32'({BASE, ack}));
    check({tag, "_done_after_wen"}, 32'(done_cyc - wen_cyc), 32'h1);
    if (m == 0) check({tag, "_no_valid"}, 32'(valid_cnt - v0), 32'h0);
    if (timed && rise_q.size() > 0)
      check({tag, "_wen_timing"}, 32'(wen_cyc - rise_q[rise_q.size() - 1]),
            32'(2*R + m*(2*R + 1)));
    check({tag, "_stall_stable"}, 32'(stall_err), 32'h0);
    mem[at(0)] = ack;  // the PS sees the acknowledge in RAM
  endtask

  initial begin
    int d0, t, x0, w0;
    rst_n = 1'b0;
    ready_mode = 1;
    stall_n = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    d0 = cyc;

    // Idle mailbox: polls only, no writes or requests.
    t = 0;
    while (rise_q.size() < 4 && t < 400) begin
      @(posedge clk); #1; t++;
    end
    check("poll_seen", 32'(rise_q.size() >= 4), 32'h1);
    if (rise_q.size() >= 4) begin
      check("first_poll", 32'(rise_q[0] - d0), 32'(P));
      for (int i = 1; i < 4; i++)
        check($sformatf("poll_gap%0d", i), 32'(rise_q[i] - rise_q[i-1]), 32'(P + R));
      for (int i = 0; i < 3; i++)
        check($sformatf("poll_busy_len%0d", i), 32'(len_q[i]), 32'(R));
    end
    check("idle_no_wen", 32'(wen_q.size()), 32'h0);
    check("idle_no_valid", 32'(valid_cnt), 32'h0);

    // Two known pairs, ready always high.
    pay[0] = 8'h6B; pay[1] = 8'h00; pay[2] = 8'h1B; pay[3] = 8'h18;
    for (int i = 4; i < 14; i++) pay[i] = 8'h00;
    run_block(2, "n2", 1'b1, 1'b1);

    // Three pairs with the controller stalling each request.
    ready_mode = 2;
    randomize_pay();
    run_block(3, "n3stall", 1'b0, 1'b1);

    // Oversized count is clamped to seven pairs and flagged.
    ready_mode = 1;
    randomize_pay();
    run_block(9, "n9", 1'b1, 1'b1);

    // Empty block right after the error block: ack must be clean.
    randomize_pay();
    run_block(0, "n0", 1'b1, 1'b1);

    // Reset in the second SEND of a three-pair block, then a full replay.
    randomize_pay();
    mem[at(1)] = 8'd3;
    for (int i = 0; i < 14; i++) mem[at(2 + i)] = pay[i];
    mem[at(0)] = 8'hA5;
    x0 = xfer_q.size(); w0 = wen_q.size();
    t = 0;
    while (!(xfer_q.size() == x0 + 1 && bus.cmd_valid) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    check("rst_second_send_seen", 32'(t < 500), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check("midrst_xfers", 32'(xfer_q.size() - x0), 32'h1);
    check("midrst_no_wen", 32'(wen_q.size() - w0), 32'h0);
    check("midrst_flag_kept", 32'(mem[at(0)]), 32'hA5);
    rst_n = 1'b1;
    run_block(3, "replay", 1'b1, 1'b0);

    // Random blocks against a random controller.
    ready_mode = 3;
    for (int it = 0; it < 5; it++) begin
      randomize_pay();
      run_block(int'($urandom_range(0, 12)), $sformatf("rand%0d", it), 1'b0, 1'b1);
    end

    check("valid_drops_after_xfer", 32'(dbl_err), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
